mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: ex_valid  in  1  EX-stage instruction valid; mem_read  in  1  load; mem_write  in  1  store.
REQ-004 SHALL have ports: funct3  in  3  RISC-V width/sign code; addr  in  32  byte address; wdata  in  32  store data (rs2).
REQ-005 SHALL have ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32  word-aligned; dmem_be  out  4; dmem_wdata  out  32; dmem_ack  in  1; dmem_rdata  in  32.
REQ-006 SHALL have ports: stall  out  1  pipeline freeze; load_data  out  32  aligned, extended load result driving the WriteBack memory source; load_valid  out  1; misalign  out  1.

Function
REQ-007 SHALL implement states IDLE, REQ, DONE; reset state IDLE.
REQ-008 A request is ex_valid & (mem_read XOR mem_write) & legal funct3; load legal = 000,001,010,100,101; store legal = 000,001,010.
REQ-009 mem_read & mem_write both high, or illegal funct3: no transaction, stall 0, state stays IDLE.
REQ-010 IDLE + request: stall combinationally 1 that cycle; latch addr, funct3, we, wdata; next state REQ.
REQ-011 REQ: dmem_req 1, stall 1; dmem_* driven only from latched values, stable until ack.
REQ-012 REQ + dmem_ack: load captures extracted dmem_rdata into load_data; next state DONE; dmem_ack in IDLE/DONE ignored.
REQ-013 DONE: stall 0, dmem_req 0; load_valid 1 for exactly this cycle if op was load; next state IDLE.
REQ-014 Minimum request-to-DONE latency 2 cycles (ack in first REQ cycle); no upper bound.
REQ-015 dmem_addr = {addr[31:2], 2'b00}.
REQ-016 SB: dmem_be = 4'b0001 << addr[1:0], dmem_wdata = byte replicated x4.
REQ-017 SH: dmem_be = 4'b0011 << (2*addr[1]), dmem_wdata = halfword replicated x2.
REQ-018 SW: dmem_be = 4'b1111, dmem_wdata = wdata; loads drive dmem_be = 4'b1111, dmem_we = 0.
REQ-019 LB/LBU: byte at addr[1:0], sign-/zero-extended to 32.
REQ-020 LH/LHU: halfword at addr[1], sign-/zero-extended to 32.
REQ-021 LW: full word.
REQ-022 load_data SHALL hold its value until the next completed load; stores do not change it.
REQ-023 A new request is not accepted in REQ or DONE; upstream holds inputs while stall = 1.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, dmem_req 0, dmem_we 0, dmem_be 0, dmem_addr 0, dmem_wdata 0, load_data 0, load_valid 0, misalign 0.
REQ-025 Reset during REQ SHALL drop dmem_req immediately and abandon the transaction; a late ack after reset is ignored.
REQ-026 stall = 0 while rst_n low.

Configuration
REQ-027 Macro MISALIGN_CHECK_EN defined: halfword request with addr[0]=1, or word request with addr[1:0]!=0, issues no dmem_req.
REQ-028 With MISALIGN_CHECK_EN defined, such a misaligned request pulses misalign 1 cycle, keeps stall 0, stays IDLE, and leaves load_data unchanged.
REQ-029 Macro undefined: misalign tied 0; no check; halfword uses addr[1], word ignores addr[1:0].

Verification
REQ-030 LW addr=0x100, ack in first REQ cycle, rdata=0xDEADBEEF -> dmem_addr 0x100, stall 2 cycles, load_valid 1 in DONE, load_data 0xDEADBEEF.
REQ-031 LB addr=0x103, rdata=0x80112233 -> load_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x00008011.
REQ-032 SB addr=0x201, wdata=0x000000A5, ack after 3 wait cycles -> dmem_be 0010, dmem_wdata 0xA5A5A5A5, dmem_we 1, stall held 5 cycles, load_valid 0.
REQ-033 rst_n low in 2nd REQ cycle of SW, then ack -> dmem_req 0 immediately, state IDLE, no load_valid.
REQ-034 mem_read=mem_write=1, or load funct3=011 -> no dmem_req, stall 0.
REQ-035 MISALIGN_CHECK_EN defined, LW addr=0x102 -> misalign 1 one cycle, no dmem_req; undefined -> dmem_addr 0x100 transaction.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline-side request signals and the data-memory bus of mem_access_unit.
// master: the access unit; slave: the surrounding pipeline and memory.
interface mem_access_unit_if;
    logic        ex_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;

    modport master (
        input  ex_valid, mem_read, mem_write, funct3, addr, wdata, dmem_ack, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output stall, load_data, load_valid, misalign
    );

    modport slave (
        output ex_valid, mem_read, mem_write, funct3, addr, wdata, dmem_ack, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  stall, load_data, load_valid, misalign
    );
endinterface

// File: rtl/mem_access_unit.sv
// RISC-V load/store unit: one outstanding data-memory access, pipeline stalled until ack.
// Optional macro MISALIGN_CHECK_EN rejects misaligned halfword/word requests with a misalign pulse.
module mem_access_unit (
    input logic               clk,
    input logic               rst_n,
    mem_access_unit_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_dmem_addr;
    logic [3:0]  r_dmem_be;
    logic [31:0] r_dmem_wdata;
    logic [31:0] r_load_data;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_legal;
    logic        w_req;
    logic        w_misalign;
    logic        w_accept;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    assign w_is_load  = bus.mem_read & ~bus.mem_write;
    assign w_is_store = bus.mem_write & ~bus.mem_read;
    assign w_legal    = w_is_load  ? (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                      : w_is_store ? (bus.funct3 inside {3'b000, 3'b001, 3'b010})
                      : 1'b0;
    assign w_req      = bus.ex_valid & w_legal;

`ifdef MISALIGN_CHECK_EN
    assign w_misalign = w_req &
                        (((bus.funct3[1:0] == 2'b01) & bus.addr[0]) |
                         ((bus.funct3[1:0] == 2'b10) & (bus.addr[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept = w_req & ~w_misalign;

    // Store lane enables and replicated data; loads always read the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.wdata;
        if (w_is_store) begin
            case (bus.funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << bus.addr[1:0];
                    w_wdata = {4{bus.wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{bus.wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_addr_lo)
            2'd0:    w_byte = bus.dmem_rdata[7:0];
            2'd1:    w_byte = bus.dmem_rdata[15:8];
            2'd2:    w_byte = bus.dmem_rdata[23:16];
            default: w_byte = bus.dmem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {24'h0, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_ext = {16'h0, w_half};
            default: w_load_ext = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = REQ;
            REQ:     if (bus.dmem_ack) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bus fields are registered at acceptance so they stay stable for the whole REQ phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_dmem_addr  <= 32'h0;
            r_dmem_be    <= 4'h0;
            r_dmem_wdata <= 32'h0;
        end else if ((r_state == IDLE) && w_accept) begin
            r_we         <= w_is_store;
            r_funct3     <= bus.funct3;
            r_addr_lo    <= bus.addr[1:0];
            r_dmem_addr  <= {bus.addr[31:2], 2'b00};
            r_dmem_be    <= w_be;
            r_dmem_wdata <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_data <= 32'h0;
        end else if ((r_state == REQ) && bus.dmem_ack && !r_we) begin
            r_load_data <= w_load_ext;
        end
    end

    assign bus.dmem_req   = (r_state == REQ);
    assign bus.dmem_we    = r_we;
    assign bus.dmem_addr  = r_dmem_addr;
    assign bus.dmem_be    = r_dmem_be;
    assign bus.dmem_wdata = r_dmem_wdata;
    assign bus.stall      = rst_n & (((r_state == IDLE) & w_accept) | (r_state == REQ));
    assign bus.load_data  = r_load_data;
    assign bus.load_valid = (r_state == DONE) & ~r_we;
    assign bus.misalign   = rst_n & (r_state == IDLE) & w_misalign;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected bus requests and load results are queued at
// issue time and compared when the DUT presents them.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mem_access_unit_if bus ();

    mem_access_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_load_q[$];
    req_t        mon_req;
    logic [31:0] mon_load;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    endtask

    function automatic logic [3:0] ref_be(input logic wr, input logic [2:0] f3,
                                          input logic [1:0] a);
        logic [3:0] be;
        be = 4'h0;
        if (!wr || f3[1:0] == 2'b10) return 4'hF;
        if (f3[1:0] == 2'b00) begin
            be[a] = 1'b1;
        end else begin
            be[{a[1], 1'b0}] = 1'b1;
            be[{a[1], 1'b1}] = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            case (f3[1:0])
                2'b00:   w[8*i +: 8] = wd[7:0];
                2'b01:   w[8*i +: 8] = wd[8*(i%2) +: 8];
                default: w[8*i +: 8] = wd[8*i +: 8];
            endcase
        end
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*a +: 8];
        h = rd[16*a[1] +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    // Scoreboard side: compare whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (rst_n && bus.dmem_req && bus.dmem_ack) begin
            if (exp_req_q.size() == 0) begin
                check("unexpected_req", 32'd1, 32'd0);
            end else begin
                mon_req = exp_req_q.pop_front();
                check("dmem_addr", bus.dmem_addr, mon_req.addr);
                check("dmem_be", {28'h0, bus.dmem_be}, {28'h0, mon_req.be});
                check("dmem_we", {31'h0, bus.dmem_we}, {31'h0, mon_req.we});
                if (mon_req.we) check("dmem_wdata", bus.dmem_wdata, mon_req.wdata);
            end
        end
        if (bus.load_valid) begin
            if (exp_load_q.size() == 0) begin
                check("unexpected_load_valid", 32'd1, 32'd0);
            end else begin
                mon_load = exp_load_q.pop_front();
                check("load_data", bus.load_data, mon_load);
            end
        end
    end

    task automatic do_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                         input int waits, input logic accept, input logic exp_mis);
        int          stalls;
        logic [31:0] ld_before;
        stalls = 0;
        @(posedge clk); #1;
        bus.ex_valid  = 1'b1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.dmem_ack  = 1'b0;
        @(negedge clk);
        ld_before = bus.load_data;
        check({tag, "_stall_issue"}, {31'h0, bus.stall}, {31'h0, accept});
        check({tag, "_misalign"}, {31'h0, bus.misalign}, {31'h0, exp_mis});
        check({tag, "_req_idle"}, {31'h0, bus.dmem_req}, 32'd0);
        if (accept) begin
            stalls += int'(bus.stall);
            exp_req_q.push_back('{addr: {a[31:2], 2'b00}, be: ref_be(wr, f3, a[1:0]),
                                  wdata: ref_wdata(f3, wd), we: wr});
            if (rd) exp_load_q.push_back(ref_load(f3, a[1:0], rdata));
            for (int i = 0; i <= waits; i++) begin
                @(posedge clk); #1;
                bus.dmem_ack   = (i == waits);
                bus.dmem_rdata = (i == waits) ? rdata : $urandom;
                @(negedge clk);
                check({tag, "_req_active"}, {31'h0, bus.dmem_req}, 32'd1);
                stalls += int'(bus.stall);
            end
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
            bus.ex_valid = 1'b0;
            @(negedge clk);
            check({tag, "_stall_done"}, {31'h0, bus.stall}, 32'd0);
            check({tag, "_req_done"}, {31'h0, bus.dmem_req}, 32'd0);
            check({tag, "_load_valid"}, {31'h0, bus.load_valid}, {31'h0, rd});
            if (!rd) check({tag, "_load_hold"}, bus.load_data, ld_before);
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, "_load_valid_off"}, {31'h0, bus.load_valid}, 32'd0);
            check({tag, "_stall_cycles"}, stalls, waits + 2);
        end else begin
            @(posedge clk); #1;
            bus.ex_valid = 1'b0;
            @(negedge clk);
            check({tag, "_no_req"}, {31'h0, bus.dmem_req}, 32'd0);
            check({tag, "_misalign_off"}, {31'h0, bus.misalign}, 32'd0);
            check({tag, "_load_unchanged"}, bus.load_data, ld_before);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ex_valid   = 1'b1;
        bus.mem_read   = 1'b1;
        bus.mem_write  = 1'b0;
        bus.funct3     = 3'b010;
        bus.addr       = 32'h100;
        bus.wdata      = 32'h0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
        #3;
        check("rst_stall", {31'h0, bus.stall}, 32'd0);
        check("rst_req", {31'h0, bus.dmem_req}, 32'd0);
        check("rst_we", {31'h0, bus.dmem_we}, 32'd0);
        check("rst_be", {28'h0, bus.dmem_be}, 32'd0);
        check("rst_addr", bus.dmem_addr, 32'h0);
        check("rst_wdata", bus.dmem_wdata, 32'h0);
        check("rst_load_data", bus.load_data, 32'h0);
        check("rst_load_valid", {31'h0, bus.load_valid}, 32'd0);
        bus.ex_valid = 1'b0;
        #20;
        rst_n = 1'b1;

        do_op("lw",  1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1, 1'b0);
        do_op("lb",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 1'b1, 1'b0);
        do_op("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 1'b1, 1'b0);
        do_op("lhu", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 2, 1'b1, 1'b0);
        do_op("lh",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 0, 1'b1, 1'b0);
        do_op("sb",  1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 3, 1'b1, 1'b0);
        do_op("sh",  1'b0, 1'b1, 3'b001, 32'h202, 32'h1234BEEF, 32'h0, 1, 1'b1, 1'b0);
        do_op("sw",  1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0, 1'b1, 1'b0);
        do_op("rdwr",    1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        do_op("ld_f011", 1'b1, 1'b0, 3'b011, 32'h300, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        do_op("st_f100", 1'b0, 1'b1, 3'b100, 32'h300, 32'h0, 32'h0, 0, 1'b0, 1'b0);
`ifdef MISALIGN_CHECK_EN
        do_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0BADF00D, 0, 1'b0, 1'b1);
        do_op("sh_mis", 1'b0, 1'b1, 3'b001, 32'h201, 32'h5555, 32'h0, 0, 1'b0, 1'b1);
`else
        do_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0BADF00D, 0, 1'b1, 1'b0);
        do_op("sh_mis", 1'b0, 1'b1, 3'b001, 32'h201, 32'h5555, 32'h0, 0, 1'b1, 1'b0);
`endif

        for (int k = 0; k < 12; k++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic        is_ld;
            is_ld = $urandom_range(0, 1) == 1;
            if (is_ld) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            a = $urandom;
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            do_op("rand", is_ld, ~is_ld, f3, a, $urandom, $urandom, $urandom_range(0, 3),
                  1'b1, 1'b0);
        end

        // Reset in the second REQ cycle of a store, then a late ack.
        @(posedge clk); #1;
        bus.ex_valid  = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b1;
        bus.funct3    = 3'b010;
        bus.addr      = 32'h300;
        bus.wdata     = 32'h12345678;
        @(negedge clk);
        check("rst_sw_stall", {31'h0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_sw_req1", {31'h0, bus.dmem_req}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", {31'h0, bus.dmem_req}, 32'd0);
        check("rst_mid_stall", {31'h0, bus.stall}, 32'd0);
        check("rst_mid_be", {28'h0, bus.dmem_be}, 32'd0);
        check("rst_mid_addr", bus.dmem_addr, 32'h0);
        check("rst_mid_load_data", bus.load_data, 32'h0);
        bus.ex_valid = 1'b0;
        bus.dmem_ack = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("late_ack_req", {31'h0, bus.dmem_req}, 32'd0);
        check("late_ack_lv", {31'h0, bus.load_valid}, 32'd0);
        check("late_ack_stall", {31'h0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {31'h0, bus.dmem_req}, 32'd0);
        check("post_rst_lv", {31'h0, bus.load_valid}, 32'd0);

        do_op("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h13579BDF, 1, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        check("req_queue_empty", exp_req_q.size(), 32'd0);
        check("load_queue_empty", exp_load_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
